// File: rtl/seg_mux_decoder.sv
// Receive-side decoder for a two-digit multiplexed seven-segment bus: rebuilds BCD digits and dps.
// Build option: define SEG_ACTIVE_LOW_EN for common-anode panels (segment bus inverted after stage 1).
module seg_mux_decoder #(
  parameter logic [7:0]  ONE_COM    = 8'b0111_1111,
  parameter logic [7:0]  TEN_COM    = 8'b1011_1111,
  parameter int unsigned STABLE_CNT = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_com,
  input  logic [7:0] seg_data,
  output logic [3:0] digit_one,
  output logic [3:0] digit_ten,
  output logic       dp_one,
  output logic       dp_ten,
  output logic       valid,
  output logic       update,
  output logic       err_seg,
  output logic       err_com
);

  localparam logic [3:0]  C_STABLE  = 4'(STABLE_CNT);
  localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED} state_t;

  state_t      r_state;
  logic [7:0]  r_com, r_data;
  logic [7:0]  r_cand_one, r_cand_ten;
  logic [3:0]  r_cnt_one, r_cnt_ten;
  logic        r_flag_one, r_flag_ten;
  logic [15:0] r_to_cnt;
  logic [3:0]  r_digit_one, r_digit_ten;
  logic        r_dp_one, r_dp_ten;
  logic        r_update, r_err_seg, r_err_com;

  logic [7:0]  w_data;
  logic        w_is_one, w_is_ten, w_illegal, w_timeout;
  logic [15:0] w_to_next;
  logic [4:0]  w_filt_one, w_filt_ten;
  logic [4:0]  w_dec;
  logic        w_commit_one, w_commit_ten, w_load_one, w_load_ten;
  logic [3:0]  w_nx_digit_one, w_nx_digit_ten;
  logic        w_nx_dp_one, w_nx_dp_ten, w_changed;

  // Returns {commit, next_count}; commit only on the sample where the count reaches the threshold.
  function automatic logic [4:0] filt_next(input logic [7:0] cand, input logic [3:0] cnt,
                                           input logic [7:0] pat);
    logic [3:0] nxt;
    logic       cmt;
    if (pat == cand) begin
      nxt = (cnt >= C_STABLE) ? C_STABLE : cnt + 4'd1;
      cmt = (nxt == C_STABLE) && (cnt != C_STABLE);
    end else begin
      nxt = 4'd1;
      cmt = (C_STABLE == 4'd1);
    end
    return {cmt, nxt};
  endfunction

  // Returns {legal, bcd}; dp bit is ignored.
  function automatic logic [4:0] seg_decode(input logic [7:0] pat);
    logic [4:0] res;
    case ({pat[7:1], 1'b0})
      8'hFC:   res = {1'b1, 4'd0};
      8'h60:   res = {1'b1, 4'd1};
      8'hDA:   res = {1'b1, 4'd2};
      8'hF2:   res = {1'b1, 4'd3};
      8'h66:   res = {1'b1, 4'd4};
      8'hB6:   res = {1'b1, 4'd5};
      8'hBE:   res = {1'b1, 4'd6};
      8'hE0:   res = {1'b1, 4'd7};
      8'hFE:   res = {1'b1, 4'd8};
      8'hF6:   res = {1'b1, 4'd9};
      default: res = 5'd0;
    endcase
    return res;
  endfunction

`ifdef SEG_ACTIVE_LOW_EN
  assign w_data = ~r_data;
`else
  assign w_data = r_data;
`endif

  assign w_is_one  = (r_com == ONE_COM);
  assign w_is_ten  = (r_com == TEN_COM);
  assign w_illegal = !w_is_one && !w_is_ten && (r_com != 8'hFF);

  assign w_to_next = (w_is_one || w_is_ten) ? 16'd0 :
                     (r_to_cnt == C_TIMEOUT) ? r_to_cnt : r_to_cnt + 16'd1;
  assign w_timeout = (w_to_next == C_TIMEOUT) && (r_state != S_IDLE);

  assign w_filt_one = filt_next(r_cand_one, r_cnt_one, w_data);
  assign w_filt_ten = filt_next(r_cand_ten, r_cnt_ten, w_data);
  assign w_dec      = seg_decode(w_data);

  // Timeout has priority over any commit on the same sample.
  assign w_commit_one = w_is_one && !w_timeout && w_filt_one[4];
  assign w_commit_ten = w_is_ten && !w_timeout && w_filt_ten[4];
  assign w_load_one   = w_commit_one && w_dec[4];
  assign w_load_ten   = w_commit_ten && w_dec[4];

  assign w_nx_digit_one = w_load_one ? w_dec[3:0] : r_digit_one;
  assign w_nx_digit_ten = w_load_ten ? w_dec[3:0] : r_digit_ten;
  assign w_nx_dp_one    = w_load_one ? w_data[0]  : r_dp_one;
  assign w_nx_dp_ten    = w_load_ten ? w_data[0]  : r_dp_ten;
  assign w_changed = {w_nx_digit_ten, w_nx_dp_ten, w_nx_digit_one, w_nx_dp_one} !=
                     {r_digit_ten, r_dp_ten, r_digit_one, r_dp_one};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_com       <= 8'hFF;
      r_data      <= 8'h00;
      r_cand_one  <= 8'h00;
      r_cand_ten  <= 8'h00;
      r_cnt_one   <= 4'd0;
      r_cnt_ten   <= 4'd0;
      r_flag_one  <= 1'b0;
      r_flag_ten  <= 1'b0;
      r_to_cnt    <= 16'd0;
      r_digit_one <= 4'd0;
      r_digit_ten <= 4'd0;
      r_dp_one    <= 1'b0;
      r_dp_ten    <= 1'b0;
      r_update    <= 1'b0;
      r_err_seg   <= 1'b0;
      r_err_com   <= 1'b0;
    end else begin
      r_com       <= seg_com;
      r_data      <= seg_data;
      r_to_cnt    <= w_to_next;
      r_err_com   <= w_illegal;
      r_err_seg   <= (w_commit_one || w_commit_ten) && !w_dec[4];
      r_digit_one <= w_nx_digit_one;
      r_digit_ten <= w_nx_digit_ten;
      r_dp_one    <= w_nx_dp_one;
      r_dp_ten    <= w_nx_dp_ten;
      r_update    <= 1'b0;
      if (w_timeout) begin
        r_state    <= S_IDLE;
        r_cand_one <= 8'h00;
        r_cand_ten <= 8'h00;
        r_cnt_one  <= 4'd0;
        r_cnt_ten  <= 4'd0;
        r_flag_one <= 1'b0;
        r_flag_ten <= 1'b0;
      end else begin
        if (w_is_one) begin
          r_cand_one <= w_data;
          r_cnt_one  <= w_filt_one[3:0];
        end
        if (w_is_ten) begin
          r_cand_ten <= w_data;
          r_cnt_ten  <= w_filt_ten[3:0];
        end
        if (w_load_one) r_flag_one <= 1'b1;
        if (w_load_ten) r_flag_ten <= 1'b1;
        case (r_state)
          S_IDLE:   if (w_is_one || w_is_ten) r_state <= S_ACQ;
          S_ACQ:    if (r_flag_one && r_flag_ten) begin
                      r_state  <= S_LOCKED;
                      r_update <= 1'b1;
                    end
          S_LOCKED: r_update <= w_changed;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign digit_one = r_digit_one;
  assign digit_ten = r_digit_ten;
  assign dp_one    = r_dp_one;
  assign dp_ten    = r_dp_ten;
  assign valid     = (r_state == S_LOCKED);
  assign update    = r_update;
  assign err_seg   = r_err_seg;
  assign err_com   = r_err_com;

endmodule

// File: tb/tb_seg_mux_decoder.sv
// Self-checking bench for seg_mux_decoder: scenario tasks plus randomized traffic vs. a sample-level model.
module tb_seg_mux_decoder;

  localparam logic [7:0] ONE = 8'b0111_1111;
  localparam logic [7:0] TEN = 8'b1011_1111;
  localparam int STABLE  = 2;
  localparam int TMO     = 1024;
`ifdef SEG_ACTIVE_LOW_EN
  localparam logic [7:0] INV = 8'hFF;
`else
  localparam logic [7:0] INV = 8'h00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] seg_com = 8'hFF;
  logic [7:0] seg_data = 8'h00;
  logic [3:0] digit_one, digit_ten;
  logic dp_one, dp_ten, valid, update, err_seg, err_com;

  seg_mux_decoder dut (
    .clk(clk), .rst(rst), .seg_com(seg_com), .seg_data(seg_data),
    .digit_one(digit_one), .digit_ten(digit_ten), .dp_one(dp_one), .dp_ten(dp_ten),
    .valid(valid), .update(update), .err_seg(err_seg), .err_com(err_com)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int mis_cycles = 0;
  int n_upd = 0, n_eseg = 0, n_ecom = 0;
  int x_upd = 0;

  // Reference model: one sample in flight in the input register, then processed per the rules.
  logic [7:0] seg_tbl [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
  logic [7:0] p_com = 8'hFF, p_pat = 8'h00;
  logic [7:0] m_cand [2];
  int         m_cnt [2];
  bit         m_flag [2];
  logic [3:0] m_dig [2];
  logic       m_dp [2];
  int         m_state = 0;
  int         m_to = 0;
  logic       e_upd = 0, e_eseg = 0, e_ecom = 0;

  function automatic int seg2bcd(input logic [7:0] p);
    for (int i = 0; i < 10; i++)
      if ((p & 8'hFE) == seg_tbl[i]) return i;
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic [7:0] com, input logic [7:0] pat);
    int idx, d, old, to_next;
    bit tmo, old_both, match;
    logic [9:0] old_t, new_t;
    if (r) begin
      m_state = 0; m_to = 0;
      for (int i = 0; i < 2; i++) begin
        m_cand[i] = 8'h00; m_cnt[i] = 0; m_flag[i] = 0; m_dig[i] = 4'd0; m_dp[i] = 1'b0;
      end
      e_upd = 0; e_eseg = 0; e_ecom = 0;
      p_com = 8'hFF; p_pat = 8'h00;
    end else begin
      idx = (p_com == ONE) ? 0 : (p_com == TEN) ? 1 : -1;
      e_ecom = (idx < 0) && (p_com != 8'hFF);
      e_upd = 0; e_eseg = 0;
      to_next = (idx >= 0) ? 0 : ((m_to < TMO) ? m_to + 1 : m_to);
      tmo = (to_next == TMO) && (m_state != 0);
      old_both = m_flag[0] && m_flag[1];
      old_t = {m_dig[1], m_dp[1], m_dig[0], m_dp[0]};
      if (tmo) begin
        m_state = 0;
        for (int i = 0; i < 2; i++) begin m_cand[i] = 8'h00; m_cnt[i] = 0; m_flag[i] = 0; end
      end else begin
        if (idx >= 0) begin
          old = m_cnt[idx];
          match = (p_pat == m_cand[idx]);
          if (match) m_cnt[idx] = (old < STABLE) ? old + 1 : STABLE;
          else begin m_cand[idx] = p_pat; m_cnt[idx] = 1; end
          if (m_cnt[idx] == STABLE && !(match && old == STABLE)) begin
            d = seg2bcd(p_pat);
            if (d < 0) e_eseg = 1;
            else begin m_dig[idx] = d[3:0]; m_dp[idx] = p_pat[0]; m_flag[idx] = 1; end
          end
        end
        new_t = {m_dig[1], m_dp[1], m_dig[0], m_dp[0]};
        case (m_state)
          0: if (idx >= 0) m_state = 1;
          1: if (old_both) begin m_state = 2; e_upd = 1; end
          default: if (new_t != old_t) e_upd = 1;
        endcase
      end
      m_to = to_next;
      p_com = com; p_pat = pat;
    end
  endtask

  // One clock: drive logical pattern (inverted on the wire for active-low panels), advance model.
  task automatic step(input logic [7:0] com, input logic [7:0] pat, input logic r);
    @(negedge clk);
    rst = r; seg_com = com; seg_data = pat ^ INV;
    @(posedge clk);
    model_edge(r, com, pat);
    #1;
    if ({digit_one, digit_ten, dp_one, dp_ten, valid, update, err_seg, err_com} !==
        {m_dig[0], m_dig[1], m_dp[0], m_dp[1], (m_state == 2), e_upd, e_eseg, e_ecom})
      mis_cycles++;
    n_upd += int'(update); n_eseg += int'(err_seg); n_ecom += int'(err_com);
    x_upd += int'(e_upd);
  endtask

  task automatic run_lock35(output int rise);
    rise = -1;
    for (int i = 0; i < 20; i++) begin
      step((i % 2 == 0) ? ONE : TEN, (i % 2 == 0) ? 8'hF2 : 8'hB6, 1'b0);
      if (valid === 1'b1 && rise < 0) rise = i;
    end
  endtask

  task automatic test_reset;
    step(8'hFF, 8'h00, 1'b1);
    step(8'hFF, 8'h00, 1'b1);
    tests++;
    if ({digit_one, digit_ten, dp_one, dp_ten, valid, update, err_seg, err_com} !== 14'd0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0",
                        {digit_one, digit_ten, dp_one, dp_ten, valid, update, err_seg, err_com});
    end
  endtask

  task automatic test_lock;
    int rise, u0;
    u0 = n_upd;
    run_lock35(rise);
    tests++; if (rise !== 5) begin fails++; $display("FAIL lock_rise_cycle: got %0d expected 5", rise); end
    tests++; if ({digit_ten, digit_one} !== 8'h53) begin fails++; $display("FAIL lock_value: got %h expected 53", {digit_ten, digit_one}); end
    tests++; if (n_upd - u0 !== 1) begin fails++; $display("FAIL lock_update_count: got %0d expected 1", n_upd - u0); end
  endtask

  task automatic test_glitch;
    int u0;
    logic [7:0] ones [4] = '{8'h60, 8'hF2, 8'hF2, 8'hF2};
    u0 = n_upd;
    for (int i = 0; i < 4; i++) begin
      step(ONE, ones[i], 1'b0);
      step(TEN, 8'hB6, 1'b0);
    end
    tests++; if (digit_one !== 4'd3) begin fails++; $display("FAIL glitch_digit: got %0d expected 3", digit_one); end
    tests++; if (n_upd - u0 !== 0) begin fails++; $display("FAIL glitch_update: got %0d expected 0", n_upd - u0); end
    tests++; if (valid !== 1'b1) begin fails++; $display("FAIL glitch_valid: got %b expected 1", valid); end
  endtask

  task automatic test_change;
    int u0;
    u0 = n_upd;
    for (int i = 0; i < 4; i++) begin
      step(ONE, 8'hFC, 1'b0);
      step(TEN, 8'hB6, 1'b0);
    end
    tests++; if (digit_one !== 4'd0) begin fails++; $display("FAIL change_digit: got %0d expected 0", digit_one); end
    tests++; if (n_upd - u0 !== 1) begin fails++; $display("FAIL change_update: got %0d expected 1", n_upd - u0); end
    tests++; if (valid !== 1'b1) begin fails++; $display("FAIL change_valid: got %b expected 1", valid); end
  endtask

  task automatic test_bad_seg;
    int e0;
    e0 = n_eseg;
    for (int i = 0; i < 4; i++) begin
      step(ONE, 8'h12, 1'b0);
      step(TEN, 8'hB6, 1'b0);
    end
    tests++; if (n_eseg - e0 !== 1) begin fails++; $display("FAIL bad_seg_pulses: got %0d expected 1", n_eseg - e0); end
    tests++; if (digit_one !== 4'd0 || valid !== 1'b1) begin
      fails++; $display("FAIL bad_seg_hold: got digit %0d valid %b expected 0/1", digit_one, valid);
    end
  endtask

  task automatic test_err_com_timeout;
    int c0;
    bit v1024, v1025;
    c0 = n_ecom;
    step(8'b0011_1111, 8'hF2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(ONE, 8'hF2, 1'b0);
      step(TEN, 8'hB6, 1'b0);
    end
    tests++; if (n_ecom - c0 !== 1) begin fails++; $display("FAIL err_com_pulses: got %0d expected 1", n_ecom - c0); end
    tests++; if (valid !== 1'b1) begin fails++; $display("FAIL err_com_valid: got %b expected 1", valid); end
    v1024 = 0; v1025 = 1;
    for (int j = 1; j <= 1100; j++) begin
      step(8'hFF, 8'h00, 1'b0);
      if (j == 1024) v1024 = valid;
      if (j == 1025) v1025 = valid;
    end
    tests++; if (v1024 !== 1'b1 || v1025 !== 1'b0) begin
      fails++; $display("FAIL timeout_edge: got valid %b/%b expected 1/0", v1024, v1025);
    end
    tests++; if ({digit_ten, digit_one} !== 8'h53) begin fails++; $display("FAIL timeout_hold: got %h expected 53", {digit_ten, digit_one}); end
  endtask

  task automatic test_reset_mid;
    int rise, u0;
    run_lock35(rise);
    step(ONE, 8'hF2, 1'b1);
    tests++;
    if ({digit_one, digit_ten, dp_one, dp_ten, valid, update, err_seg, err_com} !== 14'd0) begin
      fails++; $display("FAIL reset_mid_outputs: got %h expected 0",
                        {digit_one, digit_ten, dp_one, dp_ten, valid, update, err_seg, err_com});
    end
    u0 = n_upd;
    run_lock35(rise);
    tests++; if (rise !== 5) begin fails++; $display("FAIL relock_rise_cycle: got %0d expected 5", rise); end
    tests++; if ({digit_ten, digit_one} !== 8'h53 || n_upd - u0 !== 1) begin
      fails++; $display("FAIL relock_value: got %h upd %0d expected 53 upd 1", {digit_ten, digit_one}, n_upd - u0);
    end
  endtask

  task automatic test_random;
    logic [7:0] pat_one, pat_ten, com;
    int r, u0, xu0;
    u0 = n_upd; xu0 = x_upd;
    pat_one = 8'hF2; pat_ten = 8'hB6;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0)
        pat_one = ($urandom_range(0, 9) == 0) ? 8'($urandom) : (seg_tbl[$urandom_range(0, 9)] | 8'($urandom_range(0, 1)));
      if ($urandom_range(0, 15) == 0)
        pat_ten = ($urandom_range(0, 9) == 0) ? 8'($urandom) : (seg_tbl[$urandom_range(0, 9)] | 8'($urandom_range(0, 1)));
      r = $urandom_range(0, 99);
      if (r < 40) com = ONE;
      else if (r < 80) com = TEN;
      else if (r < 95) com = 8'hFF;
      else com = 8'b0011_1111 ^ {4'd0, 4'($urandom_range(0, 15))};
      step(com, (com == TEN) ? pat_ten : pat_one, ($urandom_range(0, 999) == 0));
    end
    tests++; if (n_upd - u0 !== x_upd - xu0) begin
      fails++; $display("FAIL random_updates: got %0d expected %0d", n_upd - u0, x_upd - xu0);
    end
    tests++; if (mis_cycles !== 0) begin
      fails++; $display("FAIL model_agreement: got %0d differing cycles expected 0", mis_cycles);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cand[i] = 8'h00; m_cnt[i] = 0; m_flag[i] = 0; m_dig[i] = 4'd0; m_dp[i] = 1'b0;
    end
    test_reset();
    test_lock();
    test_glitch();
    test_change();
    test_bad_seg();
    test_err_com_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_mux_decoder.md
Name: seg_mux_decoder

Overview:
Receive-side counterpart of the two-digit multiplexed seven-segment driver. It samples the time-multiplexed seg_com/seg_data bus and reconstructs the displayed two-digit BCD value and decimal points. A per-digit stability filter rejects glitches. Used as an on-board self-check and loopback monitor for display drivers, and as a bench checker.

Parameters:
ONE_COM, 8'b0111_1111, seg_com code that selects the ones digit (active-low select).
TEN_COM, 8'b1011_1111, seg_com code that selects the tens digit.
STABLE_CNT, 2, number of consecutive identical samples of the same digit select (range 1..15) required before a commit.
TIMEOUT, 1024, number of cycles without a legal digit select before the lock drops (range 2..65535).

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous reset, active-high
seg_com  input  8  digit select bus, active-low
seg_data  input  8  segment bus, bit7..bit0 = a,b,c,d,e,f,g,dp; active-high by default
digit_one  output  4  decoded ones digit, BCD 0..9
digit_ten  output  4  decoded tens digit, BCD 0..9
dp_one  output  1  ones decimal point
dp_ten  output  1  tens decimal point
valid  output  1  both digits committed since entering lock
update  output  1  one-cycle pulse when the output value is first valid or changes
err_seg  output  1  one-cycle pulse when a stable, non-BCD segment pattern is committed
err_com  output  1  one-cycle pulse when seg_com is not ONE_COM, TEN_COM or 8'hFF

Behaviour:
- Reset state: all outputs 0; FSM = IDLE; sample register = {8'hFF, 8'h00}; candidates cleared; counters 0.
- Stage 1: seg_com and seg_data are registered every cycle.
- Stage 2: the registered seg_com is classified as ONE, TEN, BLANK (8'hFF) or ILLEGAL.
  - ILLEGAL includes more than one select low, e.g. 8'b0011_1111.
  - ILLEGAL raises err_com for one cycle. The sample is otherwise ignored and counters keep their values.
  - BLANK is ignored silently.
- Per-digit filter (one copy for ones, one for tens), updated only on samples that select that digit:
  - If the pattern equals the candidate, the count increments, saturating at STABLE_CNT.
  - Otherwise the candidate is replaced by the new pattern and the count is set to 1.
- Commit: on the sample where the count becomes STABLE_CNT.
  - Segment map with dp masked: FC=0, 60=1, DA=2, F2=3, 66=4, B6=5, BE=6, E0=7, FE=8, F6=9.
  - A legal pattern loads the digit register and its dp bit and sets that digit's committed flag.
  - Any other pattern pulses err_seg and leaves the digit register, dp bit and committed flag unchanged.
  - Further identical samples after saturation do not re-commit.
- Latency: a sample on the input pins before edge k is registered at edge k and committed at edge k+1.
- FSM states and transitions:
  - IDLE goes to ACQ on the first ONE or TEN sample.
  - ACQ goes to LOCKED when both committed flags are set.
  - LOCKED goes to IDLE on timeout.
- valid = 1 exactly while the FSM is in LOCKED.
- update pulses in the cycle valid rises, and on every later commit in LOCKED that changes {digit_ten, dp_ten, digit_one, dp_one}.
- Timeout:
  - A counter clears on every ONE or TEN sample and increments otherwise, saturating.
  - When it reaches TIMEOUT in ACQ or LOCKED: FSM goes to IDLE, valid = 0, committed flags, candidates and counts clear.
  - digit_one, digit_ten, dp_one and dp_ten hold their last values.
- Simultaneous events:
  - A commit in the same cycle as the timeout: the timeout wins.
  - err_seg and err_com are never both set from one sample, since an ILLEGAL sample cannot commit.
- Reset mid-operation: rst overrides every other event. It returns to the reset state on the next edge, with no update pulse.

Optional Feature:
SEG_ACTIVE_LOW_EN
- Defined: seg_data is inverted after stage 1, before filtering and decode, for common-anode panels. Pattern 8'h03 decodes as 0.
- Undefined: seg_data is used as is (active-high).
- Select polarity, timing and all other behaviour are identical in both builds.

Test Plan:
1. Defaults; seg_com alternates ONE_COM/TEN_COM each cycle; seg_data = F2 on ones, B6 on tens -> valid rises after the second tens sample plus 1 cycle; digit_one=3, digit_ten=5, single update pulse.
2. Locked at 35; one ones sample of 60 inserted, then F2 resumes -> no commit, no update, digit_one stays 3.
3. Locked; ones pattern changed to FC and held -> digit_one=0 after the second ones sample; exactly one update pulse; valid stays 1.
4. Ones pattern 8'h12 held on every ones slot -> err_seg pulses once; digit_one unchanged; valid unchanged.
5. seg_com=8'b0011_1111 for 1 cycle -> err_com pulses once, no state change. Then seg_com=8'hFF for 1024 cycles -> valid falls to 0, FSM in IDLE, digits held at 3 and 5.
6. rst asserted for 1 cycle while locked -> all outputs 0 on the next edge. Re-running scenario 1 reproduces it exactly. A SEG_ACTIVE_LOW_EN build with inverted patterns gives the same results.
